// File: rtl/emmc_bridge_pkg.sv
// emmc_bridge_pkg
// Shared definitions for the eMMC SERDES bridge FIFO endpoints.
//   - WORD_W / PAR_W     : FIFO data word and parity widths
//   - BLOCK_WORDS_DEF    : default words per eMMC block (512 bytes)
//   - state_e            : drain-engine state encoding
//   - byte_parity()      : per-byte even-XOR parity in FIFO DOP bit order,
//                          used by both the write (generate) and read (check) sides
package emmc_bridge_pkg;

  localparam int WORD_W          = 32;
  localparam int PAR_W           = 4;
  localparam int BLOCK_WORDS_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // DOP[3] covers byte 0 (bits 7:0) down to DOP[0] covering byte 3 (bits 31:24).
  function automatic logic [PAR_W-1:0] byte_parity(input logic [WORD_W-1:0] data);
    byte_parity = {^data[7:0], ^data[15:8], ^data[23:16], ^data[31:24]};
  endfunction

endpackage

// File: rtl/emmc_par_check.sv
// emmc_par_check
// Combinational parity checker for one FIFO word.
//   data_i     : 32-bit word as read from the FIFO
//   dop_i      : 4 parity bits stored alongside the word
//   mismatch_o : 1 when any byte's recomputed parity disagrees with dop_i
module emmc_par_check
  import emmc_bridge_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [PAR_W-1:0]  dop_i,
  output logic              mismatch_o
);

  assign mismatch_o = |(byte_parity(data_i) ^ dop_i);

endmodule

// File: rtl/emmc_fifo_reader.sv
// emmc_fifo_reader
// Drains the AXI->SD FWFT FIFO in the sd_clk domain, checks per-byte parity and
// presents the words as a registered valid/ready stream framed into blocks.
//   sd_clk, rstn         : clock, asynchronous active-low reset
//   start, num_blocks    : transfer request (sampled only in IDLE)
//   busy, done           : transfer in progress / one-cycle end pulse
//   fifo_data_i/dop_i    : FIFO read data and parity (FWFT)
//   fifo_empty_i         : FIFO empty flag
//   fifo_rd_en_o         : FIFO read enable (combinational)
//   out_data/valid/ready : output stream; out_last marks the last word of a block
//   out_perr             : parity mismatch on the current word
//   par_err, err_cnt     : sticky error flag and saturating error-word count
module emmc_fifo_reader
  import emmc_bridge_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int CNT_W       = 16
) (
  input  logic              sd_clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_blocks,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] fifo_data_i,
  input  logic [PAR_W-1:0]  fifo_dop_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_perr,
  output logic              par_err,
  output logic [7:0]        err_cnt
);

  localparam int WC_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int PR_W = CNT_W + WC_W;
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(BLOCK_WORDS - 1);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              out_perr_q, out_perr_d;
  logic              par_err_q, par_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;   // accepted words within the block
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;     // completed (accepted) blocks
  logic [CNT_W-1:0]  blk_rem_q, blk_rem_d;     // block count requested at start
  logic [PR_W-1:0]   pop_rem_q, pop_rem_d;     // words still to be popped
  logic [WC_W-1:0]   pop_idx_q, pop_idx_d;     // block position of the next popped word

  logic pop;
  logic accept;
  logic mismatch;

  emmc_par_check u_par_check (
    .data_i     (fifo_data_i),
    .dop_i      (fifo_dop_i),
    .mismatch_o (mismatch)
  );

  // The output register can take a new word when it is empty or being emptied
  // this cycle; pop_rem stops reads exactly at the requested word total.
  assign accept = out_valid_q & out_ready;
  assign pop    = (state_q == ST_XFER) & ~fifo_empty_i & (~out_valid_q | out_ready)
                & (pop_rem_q != '0);
  assign fifo_rd_en_o = pop;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_perr_d  = out_perr_q;
    par_err_d   = par_err_q;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    blk_rem_d   = blk_rem_q;
    pop_rem_d   = pop_rem_q;
    pop_idx_d   = pop_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          par_err_d  = 1'b0;
          err_cnt_d  = '0;
          word_cnt_d = '0;
          blk_cnt_d  = '0;
          pop_idx_d  = '0;
          blk_rem_d  = num_blocks;
          pop_rem_d  = PR_W'(num_blocks) * PR_W'(BLOCK_WORDS);
          state_d    = (num_blocks == '0) ? ST_DONE : ST_XFER;
        end
      end

      ST_XFER: begin
        if (accept) begin
          out_valid_d = 1'b0;
          if (word_cnt_q == LAST_IDX) begin
            word_cnt_d = '0;
            blk_cnt_d  = blk_cnt_q + 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
          if (out_last_q && (blk_cnt_q == blk_rem_q - 1'b1)) begin
            state_d = ST_DONE;
          end
        end
        // A pop in the same cycle as an accept overrides the clear above.
        if (pop) begin
          out_data_d  = fifo_data_i;
          out_valid_d = 1'b1;
          out_perr_d  = mismatch;
          out_last_d  = (pop_idx_q == LAST_IDX);
          pop_idx_d   = (pop_idx_q == LAST_IDX) ? '0 : pop_idx_q + 1'b1;
          pop_rem_d   = pop_rem_q - 1'b1;
          if (mismatch) begin
            par_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // busy/done are registered copies of the next state so they align with it.
    busy_d = (state_d == ST_XFER);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_perr_q  <= 1'b0;
      par_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      blk_rem_q   <= '0;
      pop_rem_q   <= '0;
      pop_idx_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_perr_q  <= out_perr_d;
      par_err_q   <= par_err_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      blk_rem_q   <= blk_rem_d;
      pop_rem_q   <= pop_rem_d;
      pop_idx_q   <= pop_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_perr  = out_perr_q;
  assign par_err   = par_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_emmc_fifo_reader.sv
// tb_emmc_fifo_reader
// Directed bench for emmc_fifo_reader: an FWFT FIFO model whose word k is
// salt+k with optionally corrupted parity, a table of transfer scenarios, and
// hand-written sequences for zero-block start and reset mid-transfer.
module tb_emmc_fifo_reader;

  localparam int BW    = 128;
  localparam int CNT_W = 16;

  logic              sd_clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [CNT_W-1:0]  num_blocks;
  logic              busy, done;
  logic [31:0]       fifo_data_i;
  logic [3:0]        fifo_dop_i;
  logic              fifo_empty_i;
  logic              fifo_rd_en_o;
  logic [31:0]       out_data;
  logic              out_valid, out_ready, out_last, out_perr, par_err;
  logic [7:0]        err_cnt;

  // FIFO model state
  int          rd_idx    = 0;   // words popped since time 0
  int          bad_reads = 0;   // pops issued while empty
  int          avail;           // words loaded (absolute index bound)
  int          base;            // rd_idx at the start of the current transfer
  logic [31:0] salt;
  int          bad_a, bad_b;    // word indices (relative to base) with corrupted DOP
  bit          bad_all;
  bit          gap;             // forces the FIFO to look empty this cycle

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          nblk;
    int          rdy_pct;
    int          gap_pct;
    logic [31:0] salt;
    int          bad_a;
    int          bad_b;
    bit          bad_all;
    int          restart_at;  // cycle to pulse an (ignored) start, 0 = never
    int          abort_at;    // stop after this many accepts, 0 = run to done
    int          exp_err;
  } xfer_t;

  xfer_t vecs[5];

  emmc_fifo_reader #(.BLOCK_WORDS(BW), .CNT_W(CNT_W)) dut (
    .sd_clk       (sd_clk),
    .rstn         (rstn),
    .start        (start),
    .num_blocks   (num_blocks),
    .busy         (busy),
    .done         (done),
    .fifo_data_i  (fifo_data_i),
    .fifo_dop_i   (fifo_dop_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_perr     (out_perr),
    .par_err      (par_err),
    .err_cnt      (err_cnt)
  );

  always #5 sd_clk = ~sd_clk;

  function automatic logic [3:0] good_dop(input logic [31:0] d);
    return {^d[7:0], ^d[15:8], ^d[23:16], ^d[31:24]};
  endfunction

  always_comb begin
    fifo_data_i = salt + 32'(rd_idx);
    fifo_dop_i  = good_dop(fifo_data_i);
    if (rd_idx - base == bad_a) fifo_dop_i[3] = ~fifo_dop_i[3];
    if (rd_idx - base == bad_b) fifo_dop_i[0] = ~fifo_dop_i[0];
    if (bad_all)                fifo_dop_i[1] = ~fifo_dop_i[1];
    fifo_empty_i = gap || (rd_idx >= avail);
  end

  always @(posedge sd_clk) begin
    if (fifo_rd_en_o) begin
      rd_idx <= rd_idx + 1;
      if (fifo_empty_i) bad_reads <= bad_reads + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input xfer_t v, input string tag);
    int          total, j, cyc, budget, done_cyc;
    int          word_errs, stab_errs;
    bit          seen_done, last_acc, hold;
    logic [31:0] h_data, e_data;
    logic        h_last, h_perr, e_last, e_perr;
    total = v.nblk * BW;
    budget = total * 8 + 100;
    j = 0; cyc = 0; done_cyc = 0; word_errs = 0; stab_errs = 0;
    seen_done = 0; last_acc = 0; hold = 0;
    h_data = '0; h_last = 0; h_perr = 0;

    @(negedge sd_clk);
    base    = rd_idx;
    avail   = rd_idx + total + 8;  // extra words must never be read
    salt    = v.salt;
    bad_a   = v.bad_a;
    bad_b   = v.bad_b;
    bad_all = v.bad_all;
    start = 1'b1; num_blocks = CNT_W'(v.nblk); out_ready = 1'b1; gap = 1'b0;

    while (cyc < budget && !seen_done && !(v.abort_at != 0 && j >= v.abort_at)) begin
      @(negedge sd_clk);
      cyc++;
      start      = (cyc == v.restart_at);
      num_blocks = start ? CNT_W'(7) : CNT_W'(v.nblk);
      out_ready  = ($urandom_range(99) < v.rdy_pct);
      gap        = ($urandom_range(99) < v.gap_pct);
      #1;
      if (cyc == 1) check({tag, "_busy_rise"}, busy, 1);
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        check({tag, "_done_after_last"}, last_acc, 1);
        check({tag, "_busy_fall"}, busy, 0);
      end
      if (hold && out_valid &&
          (out_data !== h_data || out_last !== h_last || out_perr !== h_perr))
        stab_errs++;
      last_acc = 0;
      if (out_valid && out_ready) begin
        e_data = v.salt + 32'(base + j);
        e_last = ((j % BW) == BW - 1);
        e_perr = v.bad_all || (j == v.bad_a) || (j == v.bad_b);
        if (out_data !== e_data || out_last !== e_last || out_perr !== e_perr)
          word_errs++;
        if (j == total - 1) last_acc = 1;
        j++;
      end
      hold   = out_valid && !out_ready;
      h_data = out_data;
      h_last = out_last;
      h_perr = out_perr;
    end

    if (v.abort_at != 0) return;

    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_words"}, j, total);
    check({tag, "_reads"}, rd_idx - base, total);
    check({tag, "_word_errs"}, word_errs, 0);
    check({tag, "_stable"}, stab_errs, 0);
    check({tag, "_rd_empty"}, bad_reads, 0);
    check({tag, "_err_cnt"}, err_cnt, v.exp_err);
    check({tag, "_par_err"}, par_err, (v.exp_err != 0));
    if (v.rdy_pct == 100 && v.gap_pct == 0)
      check({tag, "_throughput"}, done_cyc, total + 2);
    @(negedge sd_clk);
    #1;
    check({tag, "_done_1cyc"}, {done, busy, fifo_rd_en_o}, 0);
  endtask

  initial begin
    rstn = 1'b1; start = 1'b0; num_blocks = '0; out_ready = 1'b0; gap = 1'b0;
    avail = 10; base = 0; salt = '0; bad_a = -1; bad_b = -1; bad_all = 0;

    //           nblk rdy gap salt           bad_a bad_b all  rst ab  err
    vecs[0] = '{1,   100, 0,  32'h0000_0000, -1,   -1,   1'b0, 0,  0,  0};
    vecs[1] = '{2,   60,  30, 32'h0000_0000, -1,   -1,   1'b0, 20, 0,  0};
    vecs[2] = '{3,   100, 10, 32'h1234_5600, -1,   -1,   1'b1, 0,  0,  255};
    vecs[3] = '{1,   70,  20, 32'h5A3C_0F00, 5,    9,    1'b0, 0,  0,  2};
    vecs[4] = '{2,   100, 0,  32'h0000_0000, 3,    -1,   1'b0, 0,  50, 1};

    // Reset with a non-empty FIFO: everything quiet.
    #1 rstn = 1'b0;
    repeat (3) @(negedge sd_clk);
    #1;
    check("rst_outputs", {busy, done, out_valid, out_last, out_perr, par_err,
                          fifo_rd_en_o, err_cnt, out_data}, 0);
    @(negedge sd_clk);
    rstn = 1'b1;
    repeat (5) @(negedge sd_clk);
    #1;
    check("idle_no_reads", rd_idx, 0);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 4; i++) run_xfer(vecs[i], $sformatf("v%0d", i));

    // Zero-block start: straight to DONE, no reads, errors cleared.
    @(negedge sd_clk);
    base = rd_idx; avail = rd_idx + 10; gap = 1'b0;
    start = 1'b1; num_blocks = '0;
    @(negedge sd_clk);
    start = 1'b0;
    #1;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_clr_err", {par_err, err_cnt}, 0);
    @(negedge sd_clk);
    #1;
    check("zero_done_1cyc", done, 0);
    check("zero_reads", rd_idx - base, 0);

    // Reset mid-transfer after ~50 accepted words.
    run_xfer(vecs[4], "rstmid");
    check("rstmid_pre_err", err_cnt, 1);
    @(negedge sd_clk);
    rstn = 1'b0;
    #1;
    check("rstmid_outputs", {busy, done, out_valid, out_last, out_perr, par_err,
                             fifo_rd_en_o, err_cnt, out_data}, 0);
    @(negedge sd_clk);
    rstn = 1'b1;
    run_xfer(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
